pt_write_port: RTL
==================

PT_WRITE_PORT -- requirements
Module: pt_write_port

Interface
REQ-001 Parameter: DEPTH, 8, input FIFO entries (power of two, at least 4).
REQ-002 Parameter: IMG_W, 640, frame width in pixels.
REQ-003 Parameter: IMG_H, 480, frame height in pixels.
REQ-004 Parameter: HALF_TIMEOUT, 4, idle cycles before an unpaired even pixel is issued alone.
REQ-005 clk  in  1  system clock; one clock domain; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 frame_flag  in  1  one-cycle new-frame pulse; toggles write bank.
REQ-008 pt_pixel_write  in  18  pixel data from projective_transform.
REQ-009 pt_x  in  10  pixel column.
REQ-010 pt_y  in  9  pixel row.
REQ-011 pt_wr  in  1  write strobe; one pixel per cycle when high.
REQ-012 ptflag  out  1  okay to send new data (to projective_transform).
REQ-013 mem_we  out  1  word write request (valid).
REQ-014 mem_slot  in  1  memory grants a write this cycle (ready).
REQ-015 mem_addr  out  19  {bank, word address}.
REQ-016 mem_wdata  out  36  [35:18] even-x pixel, [17:0] odd-x pixel.
REQ-017 mem_be  out  2  [1] upper half valid, [0] lower half valid.
REQ-018 overflow  out  1  sticky: a pixel was dropped because the FIFO was full.

Function
REQ-019 Push: pt_wr=1 with FIFO not full and pt_x<IMG_W and pt_y<IMG_H stores {bank, x, y, pixel}, where bank is the value after any frame_flag in that same cycle.
REQ-020 Out-of-range coordinates are silently dropped and do not set overflow.
REQ-021 pt_wr=1 while the FIFO is full drops the pixel and sets overflow; overflow clears only on reset.
REQ-022 ptflag is registered: next value is 1 when occupancy after this cycle's push/pop is <= DEPTH-2, giving one cycle of slack for a write already in flight.
REQ-023 Simultaneous push and pop on a full FIFO: the pop happens first, so the push is accepted.
REQ-024 Pack FSM has three states: EMPTY, HALF, READY.
REQ-025 EMPTY + FIFO non-empty, head x even: pop the head, hold it, go to HALF, clear the timeout counter.
REQ-026 EMPTY + FIFO non-empty, head x odd: pop the head, go to READY with mem_be=01.
REQ-027 HALF + head has the same y, same bank and x = held x+1: pop it, go to READY with mem_be=11.
REQ-028 HALF + head exists but is not the partner: do not pop; go to READY with mem_be=10, leaving the head in the FIFO.
REQ-029 HALF + FIFO empty: increment the timeout counter; at HALF_TIMEOUT consecutive empty cycles, go to READY with mem_be=10.
REQ-030 Word address = (y*IMG_W + x) >> 1, 18 bits; mem_addr = {bank, word}.
REQ-031 Unused half of mem_wdata is driven 0.
REQ-032 READY: mem_we=1 with mem_addr, mem_wdata and mem_be stable until the transfer cycle (mem_we && mem_slot).
REQ-033 After the transfer, the FSM goes to EMPTY; the next word's mem_we rises no earlier than one cycle later (at most one word per 2 cycles).
REQ-034 mem_slot while mem_we=0 is ignored.
REQ-035 Pop to mem_we latency is 1 cycle; an isolated odd pixel reaches mem_we 3 cycles after its pt_wr cycle.
REQ-036 frame_flag affects only pixels pushed afterwards; queued and held pixels keep their captured bank.
REQ-037 Pixel order into memory matches acceptance order; nothing is reordered or merged across non-adjacent entries.

Reset
REQ-038 On rst_n=0, immediately: FIFO emptied, FSM=EMPTY, bank=0, timeout=0.
REQ-039 On rst_n=0, immediately: ptflag=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, overflow=0.
REQ-040 ptflag goes to 1 on the first clock edge after rst_n deasserts.
REQ-041 Reset mid-transfer discards the pending word without a write.

Verification
REQ-042 Pixels (x=10,y=2,0x3FFFF) then (x=11,y=2,0x00001), mem_slot=1 -> one write: addr=0x00285, wdata={0x3FFFF,0x00001}, be=11.
REQ-043 Single pixel (x=10,y=2), no follow-up -> write at addr=0x00285, be=10, issued after 4 empty cycles in HALF.
REQ-044 mem_slot=0, 12 back-to-back odd-x pixels -> ptflag falls after occupancy reaches 7; overflow=1 only if pt_wr is held while full; no FIFO corruption after mem_slot=1.
REQ-045 frame_flag between pixel (x=1,y=0) and pixel (x=3,y=0) -> addresses 0x00000 then 0x40001.
REQ-046 pt_x=640 or pt_y=480 written -> no write, overflow stays 0.
REQ-047 rst_n pulled low while mem_we=1 -> all outputs 0 at once; no write after release.

Source files
------------

// File: rtl/pt_write_port.sv
// Packs transform pixels into 36-bit even/odd pairs for frame memory.
// Input register -> FIFO -> EMPTY/HALF/READY packer -> word write port.
module pt_write_port #(
  parameter int DEPTH        = 8,
  parameter int IMG_W        = 640,
  parameter int IMG_H        = 480,
  parameter int HALF_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_flag,
  input  logic [17:0] pt_pixel_write,
  input  logic [9:0]  pt_x,
  input  logic [8:0]  pt_y,
  input  logic        pt_wr,
  output logic        ptflag,
  output logic        mem_we,
  input  logic        mem_slot,
  output logic [18:0] mem_addr,
  output logic [35:0] mem_wdata,
  output logic [1:0]  mem_be,
  output logic        overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(HALF_TIMEOUT + 1);
  localparam logic [9:0]    XLIM  = 10'(IMG_W);
  localparam logic [8:0]    YLIM  = 9'(IMG_H);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] LOW   = CW'(DEPTH - 2);
  localparam logic [TW-1:0] TLAST = TW'(HALF_TIMEOUT - 1);

  typedef struct packed {
    logic        bank;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [17:0] pix;
  } ent_t;

  typedef enum logic [1:0] {S_EMPTY, S_HALF, S_READY} st_t;

  function automatic logic [18:0] f_addr(input ent_t e);
    logic [18:0] lin;
    lin = 19'(e.y) * 19'(IMG_W) + 19'(e.x);
    return {e.bank, 18'(lin >> 1)};
  endfunction

  logic          r_bank, w_bank, r_in_v;
  ent_t          r_in, w_head, r_hold;
  ent_t          r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic          w_empty, w_full, w_push, w_pop, w_drop;
  logic          r_ptflag, r_ovf;
  st_t           r_state, w_state_n;
  logic [TW-1:0] r_tmo, w_tmo_n;
  logic          w_hold_ld, w_out_ld, w_partner;
  logic [18:0]   r_addr, w_addr_n;
  logic [35:0]   r_wdata, w_wdata_n;
  logic [1:0]    r_be, w_be_n;

  // bank seen by a pixel includes a frame_flag in the same cycle
  assign w_bank = r_bank ^ frame_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank <= 1'b0;
      r_in_v <= 1'b0;
      r_in   <= '0;
    end else begin
      r_bank <= w_bank;
      r_in_v <= pt_wr && (pt_x < XLIM) && (pt_y < YLIM);
      r_in   <= {w_bank, pt_x, pt_y, pt_pixel_write};
    end
  end

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == FULL);
  assign w_head  = r_mem[r_rp];
  // pop is evaluated first, so a full FIFO still takes a push
  assign w_push  = r_in_v && (!w_full || w_pop);
  assign w_drop  = r_in_v && w_full && !w_pop;
  assign w_cnt_n = r_cnt + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= r_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_ptflag <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      r_cnt    <= w_cnt_n;
      r_ptflag <= (w_cnt_n <= LOW);
      r_ovf    <= r_ovf | w_drop;
    end
  end

  assign w_partner = (w_head.y == r_hold.y)
                  && (w_head.bank == r_hold.bank)
                  && (w_head.x == r_hold.x + 10'd1);

  always_comb begin
    w_state_n = r_state;
    w_tmo_n   = r_tmo;
    w_pop     = 1'b0;
    w_hold_ld = 1'b0;
    w_out_ld  = 1'b0;
    w_addr_n  = f_addr(r_hold);
    w_wdata_n = {r_hold.pix, 18'b0};
    w_be_n    = 2'b10;
    unique case (r_state)
      S_EMPTY: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (!w_head.x[0]) begin
            w_hold_ld = 1'b1;
            w_tmo_n   = '0;
            w_state_n = S_HALF;
          end else begin
            w_out_ld  = 1'b1;
            w_addr_n  = f_addr(w_head);
            w_wdata_n = {18'b0, w_head.pix};
            w_be_n    = 2'b01;
            w_state_n = S_READY;
          end
        end
      end
      S_HALF: begin
        if (!w_empty) begin
          w_out_ld  = 1'b1;
          w_state_n = S_READY;
          if (w_partner) begin
            w_pop     = 1'b1;
            w_wdata_n = {r_hold.pix, w_head.pix};
            w_be_n    = 2'b11;
          end
        end else if (r_tmo == TLAST) begin
          w_out_ld  = 1'b1;
          w_state_n = S_READY;
        end else begin
          w_tmo_n = r_tmo + TW'(1);
        end
      end
      S_READY: begin
        if (mem_slot) w_state_n = S_EMPTY;
      end
      default: w_state_n = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_tmo   <= '0;
      r_hold  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      r_state <= w_state_n;
      r_tmo   <= w_tmo_n;
      if (w_hold_ld) r_hold <= w_head;
      if (w_out_ld) begin
        r_addr  <= w_addr_n;
        r_wdata <= w_wdata_n;
        r_be    <= w_be_n;
      end
    end
  end

  assign mem_we    = (r_state == S_READY);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_be    = r_be;
  assign ptflag    = r_ptflag;
  assign overflow  = r_ovf;

endmodule
